// File: rtl/token_decoder.sv
// Token decoder: walks a list of token IDs and copies each zero-terminated
// vocab entry into the output RAM. Token/vocab RAMs have a 1-cycle registered read.
module token_decoder #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic [ADDR_WIDTH:0]   n_tokens,
  output logic [ADDR_WIDTH-1:0] tok_addr,
  input  logic [ADDR_WIDTH-1:0] tok_data,
  output logic [ADDR_WIDTH-1:0] voc_addr,
  input  logic [DATA_WIDTH-1:0] voc_data,
  output logic                  out_we,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   out_count,
  output logic                  done,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_TOK,
    S_LATCH_TOK,
    S_FETCH_CH,
    S_CHECK,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   n_q, n_d;
  logic [ADDR_WIDTH:0]   at_q, at_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] aw_q, aw_d;
  logic [ADDR_WIDTH-1:0] tok_addr_q, tok_addr_d;
  logic [ADDR_WIDTH-1:0] voc_addr_q, voc_addr_d;
  logic                  out_we_q, out_we_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH:0]   out_count_q, out_count_d;
  logic                  done_q, done_d;
  logic                  overflow_q, overflow_d;

  logic [ADDR_WIDTH:0]   at_inc;
  logic [ADDR_WIDTH-1:0] ptr_inc;
  logic                  end_entry;

  assign at_inc  = at_q + 1'b1;
  assign ptr_inc = ptr_q + 1'b1;

  // Addresses are registered on entry to the fetch states so that the RAM
  // data is valid in the state that follows (LATCH_TOK / CHECK).
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    n_d         = n_q;
    at_d        = at_q;
    ptr_d       = ptr_q;
    aw_d        = aw_q;
    tok_addr_d  = tok_addr_q;
    voc_addr_d  = voc_addr_q;
    out_we_d    = 1'b0;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    done_d      = done_q;
    overflow_d  = overflow_q;
    end_entry   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cs) begin
          n_d         = n_tokens;
          at_d        = '0;
          aw_d        = '0;
          out_count_d = '0;
          overflow_d  = 1'b0;
          if (n_tokens == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = S_FETCH_TOK;
            tok_addr_d = '0;
          end
        end
      end

      S_FETCH_TOK: state_d = S_LATCH_TOK;

      S_LATCH_TOK: begin
        ptr_d      = tok_data;
        voc_addr_d = tok_data;
        state_d    = S_FETCH_CH;
      end

      S_FETCH_CH: state_d = S_CHECK;

      S_CHECK: begin
        if (voc_data == '0) begin
          end_entry = 1'b1;
        end else begin
          out_we_d    = 1'b1;
          out_addr_d  = aw_q;
          out_data_d  = voc_data;
          aw_d        = aw_q + 1'b1;
          out_count_d = out_count_q + 1'b1;
          if (aw_q == ADDR_MAX) begin
            overflow_d = 1'b1;
            done_d     = 1'b1;
            state_d    = S_DONE;
          end else if (ptr_q == ADDR_MAX) begin
            // The last vocab address acts as an implicit terminator.
            end_entry = 1'b1;
          end else begin
            ptr_d      = ptr_inc;
            voc_addr_d = ptr_inc;
            state_d    = S_FETCH_CH;
          end
        end
      end

      S_DONE: begin
        if (!cs) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (end_entry) begin
      at_d = at_inc;
      if (at_inc == n_q) begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end else begin
        tok_addr_d = at_inc[ADDR_WIDTH-1:0];
        state_d    = S_FETCH_TOK;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is just the highest-priority branch
    // of the clocked block; state uses non-blocking assignments throughout.
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      at_q        <= '0;
      ptr_q       <= '0;
      aw_q        <= '0;
      tok_addr_q  <= '0;
      voc_addr_q  <= '0;
      out_we_q    <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      at_q        <= at_d;
      ptr_q       <= ptr_d;
      aw_q        <= aw_d;
      tok_addr_q  <= tok_addr_d;
      voc_addr_q  <= voc_addr_d;
      out_we_q    <= out_we_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign tok_addr  = tok_addr_q;
  assign voc_addr  = voc_addr_q;
  assign out_we    = out_we_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_token_decoder.sv
// Bench for token_decoder: directed vector table, hand-written reset/cs
// sequences, and random vocab/token streams checked against a string model.
module tb_token_decoder;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [DEPTH-1:0][DW-1:0] vocab;
    logic [DEPTH-1:0][AW-1:0] toks;
    logic [AW:0]              n;
    logic [DEPTH-1:0][DW-1:0] exp_mem;
    logic [AW:0]              exp_cnt;
    logic                     exp_ovf;
    logic [7:0]               exp_lat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs;
  logic [AW:0]   n_tokens;
  logic [AW-1:0] tok_addr, tok_data;
  logic [AW-1:0] voc_addr;
  logic [DW-1:0] voc_data;
  logic          out_we;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [AW:0]   out_count;
  logic          done, overflow;

  logic [DW-1:0] voc_mem [DEPTH];
  logic [AW-1:0] tok_mem [DEPTH];
  logic [DW-1:0] out_mem [DEPTH];
  int            wr_cnt;
  logic          clr_req;

  int n_tests = 0;
  int n_fail  = 0;

  token_decoder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .cs(cs), .n_tokens(n_tokens),
    .tok_addr(tok_addr), .tok_data(tok_data),
    .voc_addr(voc_addr), .voc_data(voc_data),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
    .out_count(out_count), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Synchronous RAM models: registered reads, write on out_we.
  always @(posedge clk) begin
    tok_data <= tok_mem[tok_addr];
    voc_data <= voc_mem[voc_addr];
    if (clr_req) begin
      for (int i = 0; i < DEPTH; i++) out_mem[i] <= 8'hEE;
      wr_cnt <= 0;
    end else if (out_we) begin
      out_mem[out_addr] <= out_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: concatenate the vocab strings named by the tokens, stopping
  // at a zero byte or after the last vocab address, truncated at 16 bytes.
  // Latency = 1 (start) + 2 per token + 2 per vocab byte read.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   cnt, lat, p;
    bit   ovf;
    r = v;
    r.exp_mem = '0;
    cnt = 0; lat = 1; ovf = 1'b0;
    for (int t = 0; t < int'(v.n) && !ovf; t++) begin
      lat += 2;
      p = int'(v.toks[t]);
      forever begin
        lat += 2;
        if (v.vocab[p] == '0) break;
        r.exp_mem[cnt] = v.vocab[p];
        cnt++;
        if (cnt == DEPTH) begin ovf = 1'b1; break; end
        if (p == DEPTH - 1) break;
        p++;
      end
    end
    r.exp_cnt = cnt[AW:0];
    r.exp_ovf = ovf;
    r.exp_lat = lat[7:0];
    return r;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < DEPTH; i++) begin
      voc_mem[i] = v.vocab[i];
      tok_mem[i] = v.toks[i];
    end
  endtask

  task automatic clear_out();
    @(negedge clk) clr_req = 1'b1;
    @(negedge clk) clr_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cs = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts a decode and counts edges, including the one that samples cs,
  // until done is seen. drop_after>0 releases cs after that many edges.
  task automatic start_and_wait(input logic [AW:0] n, input int drop_after,
                                output int lat, output bit ok);
    @(negedge clk);
    n_tokens = n; cs = 1'b1;
    lat = 0; ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (drop_after > 0 && lat == drop_after) cs = 1'b0;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run_vec(input string name, input vec_t v, input int drop_after);
    int lat;
    bit ok;
    clear_out();
    load(v);
    start_and_wait(v.n, drop_after, lat, ok);
    check({name, ":done_seen"}, ok, 1);
    if (!ok) begin
      do_reset();
      return;
    end
    if (v.exp_lat != '0) check({name, ":latency"}, lat, v.exp_lat);
    repeat (3) @(negedge clk);
    if (drop_after == 0) check({name, ":done_held"}, done, 1);
    else                 check({name, ":done_dropped"}, done, 0);
    check({name, ":out_we_quiet"}, out_we, 0);
    check({name, ":out_count"}, out_count, v.exp_cnt);
    check({name, ":overflow"}, overflow, v.exp_ovf);
    check({name, ":writes"}, wr_cnt, v.exp_cnt);
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(v.exp_cnt)) check($sformatf("%s:mem[%0d]", name, i), out_mem[i], v.exp_mem[i]);
      else                     check($sformatf("%s:mem[%0d]_untouched", name, i), out_mem[i], 8'hEE);
    end
    cs = 1'b0;
    @(negedge clk);
    check({name, ":idle_done"}, done, 0);
    @(negedge clk);
    check({name, ":idle_out_we"}, out_we, 0);
  endtask

  vec_t vecs [5];
  vec_t v, basic;

  initial begin
    rst = 1'b1; cs = 1'b0; n_tokens = '0; clr_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      voc_mem[i] = '0; tok_mem[i] = '0;
    end

    // Basic: "ab" + "c" + "ab"
    v = '0;
    v.vocab[1] = 8'h61; v.vocab[2] = 8'h62; v.vocab[3] = 8'h00;
    v.vocab[4] = 8'h63; v.vocab[5] = 8'h00;
    v.toks[0] = 4'd1; v.toks[1] = 4'd4; v.toks[2] = 4'd1;
    v.n = 5'd3;
    v.exp_mem[0] = 8'h61; v.exp_mem[1] = 8'h62; v.exp_mem[2] = 8'h63;
    v.exp_mem[3] = 8'h61; v.exp_mem[4] = 8'h62;
    v.exp_cnt = 5'd5; v.exp_ovf = 1'b0; v.exp_lat = 8'd23;
    vecs[0] = v; basic = v;

    // Empty entry followed by "c"
    v = '0;
    v.vocab[3] = 8'h00; v.vocab[4] = 8'h63; v.vocab[5] = 8'h00;
    v.toks[0] = 4'd3; v.toks[1] = 4'd4; v.n = 5'd2;
    v.exp_mem[0] = 8'h63; v.exp_cnt = 5'd1; v.exp_ovf = 1'b0; v.exp_lat = 8'd11;
    vecs[1] = v;

    // No tokens
    v = basic; v.n = 5'd0; v.exp_mem = '0;
    v.exp_cnt = 5'd0; v.exp_ovf = 1'b0; v.exp_lat = 8'd1;
    vecs[2] = v;

    // Overflow: "ABCDE" four times into a 16-byte RAM
    v = '0;
    v.vocab[1] = 8'h41; v.vocab[2] = 8'h42; v.vocab[3] = 8'h43;
    v.vocab[4] = 8'h44; v.vocab[5] = 8'h45; v.vocab[6] = 8'h00;
    for (int t = 0; t < 4; t++) v.toks[t] = 4'd1;
    v.n = 5'd4;
    for (int i = 0; i < 15; i++) v.exp_mem[i] = 8'h41 + 8'(i % 5);
    v.exp_mem[15] = 8'h41;
    v.exp_cnt = 5'd16; v.exp_ovf = 1'b1; v.exp_lat = 8'd47;
    vecs[3] = v;

    // Entry at the last vocab address; vocab[0] nonzero would expose a wrap
    v = '0;
    v.vocab[15] = 8'h7A; v.vocab[0] = 8'h55;
    v.toks[0] = 4'd15; v.n = 5'd1;
    v.exp_mem[0] = 8'h7A; v.exp_cnt = 5'd1; v.exp_ovf = 1'b0; v.exp_lat = 8'd5;
    vecs[4] = v;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset:done", done, 0);
    check("reset:overflow", overflow, 0);
    check("reset:out_we", out_we, 0);
    check("reset:out_count", out_count, 0);
    check("reset:tok_addr", tok_addr, 0);
    check("reset:voc_addr", voc_addr, 0);
    check("reset:out_addr", out_addr, 0);
    check("reset:out_data", out_data, 0);

    for (int k = 0; k < 5; k++) run_vec($sformatf("vec%0d", k), vecs[k], 0);

    // cs released mid-decode: the decode still runs to completion.
    run_vec("cs_drop", basic, 4);

    // Reset after two bytes have been written, then a clean rerun.
    begin
      bit seen2;
      clear_out();
      load(basic);
      @(negedge clk);
      n_tokens = basic.n; cs = 1'b1;
      seen2 = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (wr_cnt == 2) begin seen2 = 1'b1; break; end
      end
      check("rst_mid:two_writes", seen2, 1);
      rst = 1'b1; cs = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid:done", done, 0);
      check("rst_mid:out_we", out_we, 0);
      check("rst_mid:out_count", out_count, 0);
      check("rst_mid:tok_addr", tok_addr, 0);
      check("rst_mid:mem0_kept", out_mem[0], 8'h61);
      check("rst_mid:mem1_kept", out_mem[1], 8'h62);
      repeat (3) @(negedge clk);
      check("rst_mid:stays_idle", done | out_we, 0);
    end
    run_vec("after_rst", basic, 0);

    for (int r = 0; r < 40; r++) begin
      v = '0;
      for (int i = 0; i < DEPTH; i++) begin
        v.vocab[i] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        v.toks[i]  = 4'($urandom_range(0, DEPTH - 1));
      end
      v.n = (r % 5 == 4) ? 5'd16 : 5'($urandom_range(0, 6));
      v = model(v);
      run_vec($sformatf("rand%0d", r), v, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/token_decoder.md
Name: token_decoder

Overview:
- Inverse of the tokenizer encoder: expands a stream of token IDs back into the original byte string.
- Reads token IDs from a token RAM and, for each ID, copies its zero-terminated string from the vocab RAM into an output RAM.
- Token ID = start address of the entry in vocab RAM.
- Sits beside the encoder in the tensor_core text path and shares the same synchronous single-port SRAM model: registered read, 1-cycle latency.

Parameters:
- ADDR_WIDTH, 4, address width of the token, vocab and output RAMs (depth 2^ADDR_WIDTH each).
- DATA_WIDTH, 8, width of vocab characters and output bytes; token IDs are ADDR_WIDTH wide.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cs  in  1  chip select/start; sampled in IDLE; must stay high until done is seen.
- n_tokens  in  ADDR_WIDTH+1  number of tokens at token RAM addresses 0..n_tokens-1; sampled with cs.
- tok_addr  out  ADDR_WIDTH  token RAM read address.
- tok_data  in  ADDR_WIDTH  token RAM read data, valid 1 cycle after tok_addr.
- voc_addr  out  ADDR_WIDTH  vocab RAM read address.
- voc_data  in  DATA_WIDTH  vocab RAM read data, valid 1 cycle after voc_addr.
- out_we  out  1  output RAM write strobe, one cycle per byte.
- out_addr  out  ADDR_WIDTH  output RAM write address.
- out_data  out  DATA_WIDTH  output RAM write data.
- out_count  out  ADDR_WIDTH+1  bytes written so far.
- done  out  1  decode finished; held high while cs stays high.
- overflow  out  1  output RAM filled before the stream ended; valid with done.

Behaviour:
- Reset: state=IDLE; all outputs 0 (tok_addr, voc_addr, out_*, out_count, done, overflow); internal counters at, ptr, aw cleared.
- Reset mid-operation aborts the decode immediately. Output RAM contents already written are left as-is.
- States:
  - IDLE: if cs, latch n_tokens, clear at/aw/out_count/overflow. Go to DONE if n_tokens==0, else FETCH_TOK.
  - FETCH_TOK: tok_addr=at. Go to LATCH_TOK.
  - LATCH_TOK: ptr<=tok_data. Go to FETCH_CH.
  - FETCH_CH: voc_addr=ptr. Go to CHECK.
  - CHECK, voc_data==0 (end of entry): at<=at+1. If at+1==n_tokens go to DONE, else FETCH_TOK.
  - CHECK, voc_data!=0: register a write, out_we=1, out_addr=aw, out_data=voc_data, visible the cycle after CHECK. Then aw<=aw+1, out_count<=out_count+1.
    - If aw was 2^ADDR_WIDTH-1 (output full): overflow<=1, go to DONE.
    - Else if ptr==2^ADDR_WIDTH-1: ptr never wraps; end of memory counts as terminator; treat as end of entry (at<=at+1, same DONE/FETCH_TOK test).
    - Else ptr<=ptr+1, go to FETCH_CH.
  - DONE: done=1. out_we pulse from the final CHECK still completes. Stay in DONE until cs==0, then go to IDLE and clear done.
- out_we is a one-cycle pulse per byte and is never high in IDLE.
- Timing: 2 cycles per token fetch plus 2 cycles per vocab byte read, including the terminator read.
- Empty entry (first byte 0): no write, next token.
- Duplicate token IDs are legal.
- cs low mid-decode is ignored; the decode completes.
- overflow and done rise together. A stream that exactly fills the output RAM with its last byte ends via the overflow path, with out_count=2^ADDR_WIDTH.

Test Plan:
- Basic: vocab[1..5]={61,62,00,63,00}, tokens={1,4,1}, n_tokens=3, cs=1 -> output RAM[0..4]={61,62,63,61,62}, out_count=5, overflow=0, done high 23 edges after cs sampled.
- Empty entry: vocab[3]=00, tokens={3,4}, vocab[4..5]={63,00} -> single write 63 at addr 0, out_count=1.
- n_tokens=0, cs=1 -> done next cycle, out_we never asserted, out_count=0.
- Overflow: vocab[1..6]={41,42,43,44,45,00}, tokens={1,1,1,1} -> 16 writes, out_count=16, overflow=1, done=1, RAM[15]=41.
- End-of-memory entry: vocab[15]=7A, tokens={15} -> one write 7A, no wrap read of vocab[0], done, overflow=0.
- rst=1 mid-decode, after 2 bytes written -> next cycle state IDLE, done=0, out_we=0. Re-assert cs -> full correct decode from token 0.
